buzzer_sequencer: RTL
=====================

# buzzer_sequencer

Memory-mapped note sequencer that plays a queued melody on the Buzzer peripheral without CPU involvement per note. The CPU pushes {divider, duration} notes into an 8-entry FIFO over the peripheral bus. The sequencer pops each note and programs the Buzzer through its register port (divider at offset 0, enable at offset 2). It holds each note for a timed duration and inserts a silent gap between notes.

## Interface
- TICK_DIV, 50000, clock cycles per duration unit (≥1)
- GAP_CYCLES, 16, silent cycles between notes (≥1)
- DEPTH_LOG2, 3, FIFO depth = 2^DEPTH_LOG2 entries
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- Select  in  1  chip select for this block
- Write_enable  in  1  bus write strobe (qualified by Select)
- Read_enable  in  1  bus read strobe (qualified by Select)
- Address  in  3  register offset: 0 = DIV, 2 = DUR_PUSH, 4 = CTRL/STATUS
- Write_data_in  in  16  bus write data
- Read_data_out  out  16  STATUS when Select & Read_enable & Address==4, else 0 (combinational)
- Buzzer_select  out  1  drives Buzzer Select
- Buzzer_write_enable  out  1  drives Buzzer Write_enable
- Buzzer_address  out  2  drives Buzzer Address
- Buzzer_write_data  out  16  drives Buzzer Write_data_in

## Operation
- Register writes take effect only when Select & Write_enable are both high.
- DIV write: latches the staging divider register.
- DUR_PUSH write: pushes {staging divider, Write_data_in} into the FIFO. Push while full is dropped and sets sticky `ovf`.
- CTRL write controls:
  - bit0 → `run`.
  - bit1 = 1 → flush the FIFO.
  - bit2 = 1 → clear `ovf`.
- STATUS read format: [0] busy (state≠IDLE), [1] full, [2] empty, [3] ovf, [7:4] count (0..8), [8] run, others 0.
- FSM states: IDLE, SET_MAX, SET_ON, PLAY, SET_OFF, GAP.
  - IDLE: if run & !empty → pop the head into the note register, go to SET_MAX.
  - SET_MAX: Buzzer_write_enable=1, addr=00, data=divider → SET_ON.
  - SET_ON: we=1, addr=10. data=1, except data=0 if divider==0 (rest) → PLAY.
  - PLAY: counts duration×TICK_DIV cycles, then → SET_OFF. Duration 0 is treated as 1.
  - SET_OFF: we=1, addr=10, data=0 → GAP.
  - GAP: GAP_CYCLES cycles → SET_MAX if run & !empty (pop on exit), else IDLE.
- In any non-IDLE state other than SET_OFF and GAP, run==0 or flush → next state SET_OFF, then GAP, then IDLE. An aborted note is always silenced by an explicit enable=0 write.
- Buzzer_select:
  - High in every state except IDLE.
  - Dropping to 0 in IDLE also resets the Buzzer (output low, divider FFFF).
- Buzzer outputs are Moore-decoded from the state register. In IDLE, PLAY and GAP: we=0, addr=00, data=0.
- Duration counter is 32 bits: duration (16 b) × TICK_DIV must not overflow. Implementation uses a prescaler plus a 16-bit unit counter.
- FIFO push and pop in the same cycle: both occur, count unchanged.
- Flush and push in the same cycle: flush wins, FIFO empty.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - FIFO empty, count 0; run=0, ovf=0; staging divider 0.
- Push at edge k → count/empty visible after edge k.
- IDLE pop at edge k → SET_MAX in cycle k+1, SET_ON k+2, PLAY from k+3.
- PLAY lasts exactly duration×TICK_DIV cycles. Then SET_OFF for 1 cycle, GAP for exactly GAP_CYCLES cycles.
- Per-note period = 3 + duration×TICK_DIV + GAP_CYCLES cycles (back-to-back from FIFO).
- Abort latency: run cleared at edge k → SET_OFF in cycle k+1.
- Async reset mid-note: outputs drop to 0 without waiting for a clock edge. Buzzer_select=0 resets the Buzzer.

## Test plan
- Reset check: hold reset=0 mid-PLAY → all outputs 0 immediately; STATUS reads 0x0004 after release.
- Single note: TICK_DIV=4, GAP_CYCLES=2; DIV=0x0010, DUR_PUSH=3, CTRL=1 → Buzzer sees write {00,0x0010} then {10,1}, 12 PLAY cycles, write {10,0}, 2 gap cycles, Buzzer_select falls, STATUS=0x0104.
- Queue of 3 notes, one a rest (divider 0) → three back-to-back sequences with period 3+dur×4+2; rest writes enable=0; count decrements 3→0 at each pop.
- Overflow: push 9 notes with run=0 → full=1, count=8, ovf=1, ninth note dropped. CTRL=0x4 clears ovf, count unchanged.
- Abort: CTRL=0 during PLAY → next cycle SET_OFF write {10,0}, GAP, IDLE; remaining FIFO entries retained.
- Flush: CTRL=0x3 during PLAY → FIFO empty, SET_OFF next cycle, returns to IDLE after GAP despite run=1.

Source files
------------

// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: bus-programmed note FIFO that plays a melody on the Buzzer
// peripheral through its register port. Each note is {divider, duration}; the
// sequencer writes the divider, enables the tone, holds it for duration units,
// silences it with an explicit enable=0 write and waits a fixed gap.
module buzzer_sequencer #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Select,
  input  logic        Write_enable,
  input  logic        Read_enable,
  input  logic [2:0]  Address,
  input  logic [15:0] Write_data_in,
  output logic [15:0] Read_data_out,
  output logic        Buzzer_select,
  output logic        Buzzer_write_enable,
  output logic [1:0]  Buzzer_address,
  output logic [15:0] Buzzer_write_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_MAX = 3'd1,
    ST_SET_ON  = 3'd2,
    ST_PLAY    = 3'd3,
    ST_SET_OFF = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [15:0]           r_stage_div;
  logic                  r_run;
  logic                  r_ovf;
  logic [15:0]           r_note_div;
  logic [15:0]           r_note_dur;
  logic [PRE_W-1:0]      r_pre;
  logic [15:0]           r_units;
  logic [GAP_W-1:0]      r_gap;

  logic        w_wr;
  logic        w_wr_div;
  logic        w_push;
  logic        w_ctrl;
  logic        w_flush;
  logic        w_ovf_clr;
  logic        w_full;
  logic        w_empty;
  logic        w_push_ok;
  logic        w_pop;
  logic        w_can_pop;
  logic        w_run_next;
  logic        w_abort;
  logic        w_play_done;
  logic        w_gap_done;
  logic        w_busy;
  logic [15:0] w_status;

  assign w_wr      = Select & Write_enable;
  assign w_wr_div  = w_wr & (Address == 3'd0);
  assign w_push    = w_wr & (Address == 3'd2);
  assign w_ctrl    = w_wr & (Address == 3'd4);
  assign w_flush   = w_ctrl & Write_data_in[1];
  assign w_ovf_clr = w_ctrl & Write_data_in[2];
  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == CNT_ZERO);
  // A flush in the same cycle discards the push, so the FIFO ends up empty.
  assign w_push_ok = w_push & ~w_full & ~w_flush;
  // Never start a note out of a FIFO that is being flushed this cycle.
  assign w_can_pop = r_run & ~w_empty & ~w_flush;
  // A CTRL write clearing run aborts on the same edge that latches it.
  assign w_run_next  = w_ctrl ? Write_data_in[0] : r_run;
  assign w_abort     = ~w_run_next | w_flush;
  assign w_play_done = (r_pre == PRE_LAST) && (r_units == 16'd1);
  assign w_gap_done  = (r_gap == GAP_LAST);
  assign w_busy      = (r_state != ST_IDLE);
  assign w_status    = {7'd0, r_run, 4'(r_count), r_ovf, w_empty, w_full, w_busy};

  // Combinational STATUS read port; reads of any other offset return zero.
  always_comb begin
    Read_data_out = 16'h0000;
    if (Select && Read_enable && (Address == 3'd4)) begin
      Read_data_out = w_status;
    end else begin
      Read_data_out = 16'h0000;
    end
  end

  // Bus-visible control registers: staging divider, run and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stage_div <= 16'h0000;
      r_run       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_wr_div) begin
        r_stage_div <= Write_data_in;
      end
      if (w_ctrl) begin
        r_run <= Write_data_in[0];
      end
      if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end else if (w_push && w_full && !w_flush) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // FIFO storage; entries need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= {r_stage_div, Write_data_in};
    end
  end

  // FIFO pointers and occupancy; flush takes priority over push and pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= CNT_ZERO;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= CNT_ZERO;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Current note register, loaded from the FIFO head on every pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_note_div <= 16'h0000;
      r_note_dur <= 16'h0000;
    end else if (w_pop) begin
      r_note_div <= r_mem[r_rptr][31:16];
      r_note_dur <= r_mem[r_rptr][15:0];
    end
  end

  // Note timing: prescaler of TICK_DIV cycles times a 16-bit unit counter,
  // armed in SET_ON; a zero duration plays as one unit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre   <= '0;
      r_units <= 16'd0;
    end else if (r_state == ST_SET_ON) begin
      r_pre   <= '0;
      r_units <= (r_note_dur == 16'd0) ? 16'd1 : r_note_dur;
    end else if (r_state == ST_PLAY) begin
      if (r_pre == PRE_LAST) begin
        r_pre   <= '0;
        r_units <= r_units - 16'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // Inter-note gap counter, armed in SET_OFF and advanced through GAP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gap <= '0;
    end else if (r_state == ST_SET_OFF) begin
      r_gap <= '0;
    end else if (r_state == ST_GAP) begin
      r_gap <= r_gap + 1'b1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, pop request and Moore-decoded Buzzer register writes.
  always_comb begin
    w_state_next        = r_state;
    w_pop               = 1'b0;
    Buzzer_select       = 1'b0;
    Buzzer_write_enable = 1'b0;
    Buzzer_address      = 2'b00;
    Buzzer_write_data   = 16'h0000;
    case (r_state)
      ST_IDLE: begin
        if (w_can_pop) begin
          w_pop        = 1'b1;
          w_state_next = ST_SET_MAX;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SET_MAX: begin
        Buzzer_select       = 1'b1;
        Buzzer_write_enable = 1'b1;
        Buzzer_address      = 2'b00;
        Buzzer_write_data   = r_note_div;
        if (w_abort) begin
          w_state_next = ST_SET_OFF;
        end else begin
          w_state_next = ST_SET_ON;
        end
      end
      ST_SET_ON: begin
        Buzzer_select       = 1'b1;
        Buzzer_write_enable = 1'b1;
        Buzzer_address      = 2'b10;
        // A zero divider marks a rest: the tone stays disabled.
        Buzzer_write_data   = (r_note_div == 16'h0000) ? 16'h0000 : 16'h0001;
        if (w_abort) begin
          w_state_next = ST_SET_OFF;
        end else begin
          w_state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        Buzzer_select = 1'b1;
        if (w_abort || w_play_done) begin
          w_state_next = ST_SET_OFF;
        end else begin
          w_state_next = ST_PLAY;
        end
      end
      ST_SET_OFF: begin
        Buzzer_select       = 1'b1;
        Buzzer_write_enable = 1'b1;
        Buzzer_address      = 2'b10;
        Buzzer_write_data   = 16'h0000;
        w_state_next        = ST_GAP;
      end
      ST_GAP: begin
        Buzzer_select = 1'b1;
        if (w_gap_done) begin
          if (w_can_pop) begin
            w_pop        = 1'b1;
            w_state_next = ST_SET_MAX;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_state_next = ST_GAP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
